srt_digit_gen: RTL and testbench
================================

# srt_digit_gen

Radix-2 SRT division recurrence that produces one signed quotient digit per clock in {-1, 0, +1}. It sits directly upstream of the on-the-fly quotient converter and drives that converter's `valid` and `in[1:0]` inputs. The converter assembles the binary quotient without a final carry-propagate add. This block also holds the partial remainder and reports the final remainder and its sign, so that downstream logic can apply the quotient correction.

## Interface
- `WIDTH`, 16: operand width. Also the number of digits emitted per division.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Accepted only in IDLE.
- `dividend` in WIDTH: unsigned fraction x = 0.dividend. Sampled on the accepted `start`.
- `divisor` in WIDTH: unsigned fraction d = 0.divisor. Must be normalized (msb = 1). Sampled on the accepted `start`.
- `busy` out 1: high in RUN and DONE.
- `valid` out 1: `digit` is meaningful this cycle.
- `digit` out 2: digit code. 00 = 0, 01 = +1, 10 = -1. Code 11 is never driven.
- `done` out 1: one-cycle pulse after the last digit, or after an error.
- `err` out 1: divisor not normalized. Valid while `done` = 1.
- `rem` out WIDTH+3: final partial remainder, two's complement, binary point after bit WIDTH. Held until the next accepted `start`.
- `rem_neg` out 1: sign of `rem`. Held until the next accepted `start`.

## Operation
- Remainder register R is WIDTH+3 bits, two's complement: sign bit, 2 integer bits, WIDTH fraction bits. D holds d zero-extended.
- On an accepted `start`:
  - R <= x/2, i.e. {3'b000, dividend} >> 1.
  - Load D and clear the digit counter.
  - If `divisor[WIDTH-1]` = 0, go to DONE with `err` = 1 and emit no digits.
- Each RUN cycle:
  - Form S = 2R.
  - Select the digit exactly from the three MSBs of S (sign, int1, frac1):
    - +1 if !sign && (int1 | frac1), i.e. S >= 1/2.
    - -1 if sign && !(int1 & frac1), i.e. S < -1/2.
    - otherwise 0.
  - Update R <= S - D for +1, S + D for -1, S for 0.
  - Drive `valid` = 1 and the digit code for this cycle.
- Invariant: |R| < d at all times. The result is q = x/(2d) in [0, 1); the final quotient is exact after correction when `rem_neg` = 1.
- FSM:
  - IDLE: wait for `start`. Go to RUN, or to DONE on error.
  - RUN: WIDTH cycles, counter 0..WIDTH-1. Leave for DONE when the counter reaches WIDTH-1.
  - DONE: one cycle. Assert `done`, then return to IDLE.
- `start` while `busy` is ignored. Operands are not re-sampled.
- Reset (any state, including mid-division):
  - State goes to IDLE.
  - R, D and the counter are cleared.
  - `valid`, `done`, `err`, `busy` and `rem_neg` = 0, `digit` = 00, `rem` = 0.
  - The downstream converter sees no further `valid`.

## Timing
- Start is accepted at edge 0. Digits are valid in cycles 1..WIDTH, one per cycle, with no bubbles.
- `done` is high in cycle WIDTH+1. `rem` and `rem_neg` are valid from that cycle.
- A new `start` is accepted in cycle WIDTH+2 at the earliest. Throughput is one division per WIDTH+2 cycles.
- Error path: `done` and `err` are high in cycle 1. No `valid` is ever asserted.
- `digit` is registered and changes only on clock edges. It is 00 whenever `valid` = 0.

## Structure
- Shared package `srt_pkg` holds:
  - digit code constants DIG_ZERO = 2'b00, DIG_POS = 2'b01, DIG_NEG = 2'b10. The converter uses the same codes.
  - FSM state enum {IDLE, RUN, DONE}.
  - localparam R_W = WIDTH+3.
- One sub-module, `srt_qsel`: combinational 3-bit digit selection from S. It outputs the digit code plus add/sub controls and is reusable for a later carry-save variant.
- Top level: FSM, counter, R/D registers, adder/subtractor.

## Test plan
- x = 0x4000, d = 0x8000 -> digits 0, +1, then fourteen 0s; `rem` = 0, `rem_neg` = 0; `done` in cycle 17.
- x = 0xC000, d = 0x8000 -> digits +1, +1, then fourteen 0s; `rem` = 0.
- x = 0x2000, d = 0xC000 -> digits 0, 0, +1, then alternating 0, -1 to the end; code 11 never appears; `rem_neg` = 1.
- d = 0x7FFF, any x -> `done` and `err` in cycle 1; `valid` never asserted; `busy` is high for that one cycle only.
- `start` pulsed at cycles 5 and 9 during a run -> ignored; exactly 16 digits come from the first operands.
- `reset` low at digit 7 -> `valid`, `busy` and `digit` fall asynchronously; after release, a fresh start gives the correct full digit stream.

Source files
------------

// File: rtl/srt_pkg.sv
// Shared definitions for the radix-2 SRT digit generator and its downstream
// on-the-fly quotient converter.
`default_nettype none

package srt_pkg;

  localparam int WIDTH = 16;
  localparam int R_W   = WIDTH + 3;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/srt_qsel.sv
// Radix-2 SRT quotient-digit selection from the top three bits of 2R
// (sign, ones bit, first fraction bit).
`default_nettype none

module srt_qsel
  import srt_pkg::*;
(
  input  logic [2:0] s_top_i,
  output logic [1:0] digit_o,
  output logic       sub_o,
  output logic       add_o
);

  logic pos;
  logic neg;

  // +1 when S >= 1/2, -1 when S < -1/2; the boundary S = -1/2 selects 0.
  assign pos = ~s_top_i[2] & (s_top_i[1] | s_top_i[0]);
  assign neg =  s_top_i[2] & ~(s_top_i[1] & s_top_i[0]);

  assign sub_o = pos;
  assign add_o = neg;

  always_comb begin
    digit_o = DIG_ZERO;
    if (pos) begin
      digit_o = DIG_POS;
    end else if (neg) begin
      digit_o = DIG_NEG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/srt_digit_gen.sv
// Radix-2 SRT division recurrence: one signed quotient digit per clock,
// plus the final partial remainder and its sign for quotient correction.
`default_nettype none

module srt_digit_gen
  import srt_pkg::*;
#(
  parameter int WIDTH = srt_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [1:0]       digit,
  output logic             done,
  output logic             err,
  output logic [WIDTH+2:0] rem,
  output logic             rem_neg
);

  localparam int RW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t          state_q;
  logic [RW-1:0]   r_q;
  logic [RW-1:0]   d_q;
  logic [CW-1:0]   cnt_q;
  logic            err_pend_q;
  logic            busy_q;
  logic            valid_q;
  logic [1:0]      digit_q;
  logic            done_q;
  logic            err_q;

  logic [RW-1:0]   s;
  logic [RW-1:0]   r_d;
  logic [1:0]      dig_sel;
  logic            do_sub;
  logic            do_add;

  assign s = {r_q[RW-2:0], 1'b0};

  srt_qsel u_qsel (
    .s_top_i ({s[RW-1], s[WIDTH], s[WIDTH-1]}),
    .digit_o (dig_sel),
    .sub_o   (do_sub),
    .add_o   (do_add)
  );

  always_comb begin
    r_d = s;
    if (do_sub) begin
      r_d = s - d_q;
    end else if (do_add) begin
      r_d = s + d_q;
    end
  end

  // Outputs are registered one cycle behind the state, so busy covers the
  // digit cycles and the done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      r_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      digit_q    <= DIG_ZERO;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      busy_q  <= (state_q != IDLE);
      valid_q <= 1'b0;
      digit_q <= DIG_ZERO;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            r_q        <= {4'b0000, dividend[WIDTH-1:1]};
            d_q        <= {3'b000, divisor};
            cnt_q      <= '0;
            err_pend_q <= ~divisor[WIDTH-1];
            state_q    <= divisor[WIDTH-1] ? RUN : DONE;
          end
        end
        RUN: begin
          r_q     <= r_d;
          valid_q <= 1'b1;
          digit_q <= dig_sel;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          err_q   <= err_pend_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign digit   = digit_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rem     = r_q;
  assign rem_neg = r_q[RW-1];

endmodule

`default_nettype wire

// File: tb/tb_srt_digit_gen.sv
// Directed self-checking bench for srt_digit_gen with hand-computed digit
// streams and remainders.
`default_nettype none

module tb_srt_digit_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        valid;
  logic [1:0]  digit;
  logic        done;
  logic        err;
  logic [18:0] rem;
  logic        rem_neg;

  int n_checks = 0;
  int n_err    = 0;

  srt_digit_gen #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .valid    (valid),
    .digit    (digit),
    .done     (done),
    .err      (err),
    .rem      (rem),
    .rem_neg  (rem_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Digit n (1-based) expected at exp_dig[2n-1:2n-2].
  task automatic run_div(input string tag, input logic [15:0] x, input logic [15:0] d,
                         input logic [31:0] exp_dig, input logic [18:0] exp_rem,
                         input logic exp_neg, input bit inject);
    logic [1:0] e;
    @(negedge clk);
    dividend = x;
    divisor  = d;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " c0 busy"}, {31'd0, busy}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      e = exp_dig[2*(k-1) +: 2];
      check($sformatf("%s digit%0d", tag, k), {29'd0, valid, digit}, {29'd0, 1'b1, e});
      check($sformatf("%s busy%0d", tag, k), {31'd0, busy}, 32'd1);
      if (inject) begin
        start    = (k == 5 || k == 9);
        dividend = 16'hFFFF;
        divisor  = 16'hC000;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, " done"},    {31'd0, done},    32'd1);
    check({tag, " err"},     {31'd0, err},     32'd0);
    check({tag, " busy17"},  {31'd0, busy},    32'd1);
    check({tag, " valid17"}, {31'd0, valid},   32'd0);
    check({tag, " rem"},     {13'd0, rem},     {13'd0, exp_rem});
    check({tag, " rem_neg"}, {31'd0, rem_neg}, {31'd0, exp_neg});
    @(negedge clk);
    check({tag, " done18"},  {31'd0, done},    32'd0);
    check({tag, " busy18"},  {31'd0, busy},    32'd0);
    check({tag, " valid18"}, {31'd0, valid},   32'd0);
    check({tag, " remhold"}, {13'd0, rem},     {13'd0, exp_rem});
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst busy",  {31'd0, busy},  32'd0);
    check("rst valid", {31'd0, valid}, 32'd0);
    check("rst digit", {30'd0, digit}, 32'd0);
    check("rst done",  {31'd0, done},  32'd0);
    check("rst err",   {31'd0, err},   32'd0);
    check("rst rem",   {13'd0, rem},   32'd0);
    check("rst neg",   {31'd0, rem_neg}, 32'd0);
    reset = 1'b1;

    // 0.25 / 0.5 -> q = 0.25: digits 0,+1,0...
    run_div("t1", 16'h4000, 16'h8000, 32'h0000_0004, 19'h0, 1'b0, 1'b0);
    // 0.75 / 0.5 -> q = 0.75: digits +1,+1,0...
    run_div("t2", 16'hC000, 16'h8000, 32'h0000_0005, 19'h0, 1'b0, 1'b0);
    // 0.125 / 0.75: 0,0,+1 then 0,-1 alternating; final R = -1/2
    run_div("t3", 16'h2000, 16'hC000, 32'h2222_2210, 19'h78000, 1'b1, 1'b0);
    // zero dividend
    run_div("t0", 16'h0000, 16'h8000, 32'h0000_0000, 19'h0, 1'b0, 1'b0);
    // start pulses mid-run with other operands must be ignored
    run_div("ign", 16'h4000, 16'h8000, 32'h0000_0004, 19'h0, 1'b0, 1'b1);

    // unnormalized divisor -> error path
    @(negedge clk);
    dividend = 16'h1234;
    divisor  = 16'h7FFF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err c0 valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    check("err done",  {31'd0, done},  32'd1);
    check("err err",   {31'd0, err},   32'd1);
    check("err busy",  {31'd0, busy},  32'd1);
    check("err valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    check("err done2", {31'd0, done},  32'd0);
    check("err err2",  {31'd0, err},   32'd0);
    check("err busy2", {31'd0, busy},  32'd0);
    check("err valid2", {31'd0, valid}, 32'd0);

    // reset asserted at digit 7 of a 0.75/0.5 run
    @(negedge clk);
    dividend = 16'hC000;
    divisor  = 16'h8000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("mid digit%0d", k), {29'd0, valid, digit},
            (k <= 2) ? 32'h5 : 32'h4);
    end
    #2 reset = 1'b0;
    #1;
    check("async valid", {31'd0, valid}, 32'd0);
    check("async busy",  {31'd0, busy},  32'd0);
    check("async digit", {30'd0, digit}, 32'd0);
    check("async rem",   {13'd0, rem},   32'd0);
    @(negedge clk);
    check("rst hold valid", {31'd0, valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post rst valid", {31'd0, valid}, 32'd0);
    run_div("post", 16'h2000, 16'hC000, 32'h2222_2210, 19'h78000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
